// File: rtl/pool_fmap_loader_if.sv
// Sample stream in and per-bank BRAM write bus out for the pooling feature-map loader.
// The loader connects through the master modport; the surrounding logic uses the slave modport.
interface pool_fmap_loader_if #(
  parameter int COMPUTING_CORES             = 4,
  parameter int number_datawidth            = 16,
  parameter int input_map_address_datawidth = 13
);
  logic                                               s_valid;
  logic [number_datawidth-1:0]                        s_data;
  logic                                               s_last;
  logic                                               s_ready;
  logic [COMPUTING_CORES-1:0]                         wr_ena;
  logic [COMPUTING_CORES*input_map_address_datawidth-1:0] wr_addr;
  logic [COMPUTING_CORES*number_datawidth-1:0]        wr_data;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, wr_ena, wr_addr, wr_data
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, wr_ena, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_fmap_loader.sv
// Packs COMPUTING_CORES consecutive stream samples into one parallel write across the
// per-core feature-map BRAM banks. The global layer state code selects the map size.
module pool_fmap_loader #(
  parameter int COMPUTING_CORES             = 4,
  parameter int number_datawidth            = 16,
  parameter int input_map_address_datawidth = 13,
  parameter int STATE_DATAWIDTH             = 4,
  parameter int LOAD1_STATE                 = 2,
  parameter int LOAD2_STATE                 = 5,
  parameter int LOAD3_STATE                 = 8,
  parameter int LOAD1_SIZE                  = 80,
  parameter int LOAD2_SIZE                  = 36,
  parameter int LOAD3_SIZE                  = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STATE_DATAWIDTH-1:0] state,
  pool_fmap_loader_if.master         bus,
  output logic                       done,
  output logic                       err_last
);
  localparam int AW = input_map_address_datawidth;
  localparam int DW = number_datawidth;
  localparam int LW = (COMPUTING_CORES > 1) ? $clog2(COMPUTING_CORES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} fsm_t;
  fsm_t fsm, fsm_nxt;

  logic [STATE_DATAWIDTH-1:0]    load_code;
  logic [AW-1:0]                 last_pix;
  logic [AW-1:0]                 pix_cnt;
  logic [AW-1:0]                 match_last;
  logic [LW-1:0]                 lane_cnt;
  logic [DW-1:0]                 lane_q [COMPUTING_CORES];
  logic [COMPUTING_CORES*DW-1:0] packed_lanes;
  logic                          load_match;
  logic                          stay;
  logic                          accept;
  logic                          lane_full;
  logic                          final_smp;
  logic [COMPUTING_CORES-1:0]    wr_ena_q;
  logic [COMPUTING_CORES*AW-1:0] wr_addr_q;
  logic [COMPUTING_CORES*DW-1:0] wr_data_q;
  logic                          err_q;

  // Decode the layer state into "is a load" plus the last pixel address of that map.
  always_comb begin
    load_match = 1'b1;
    match_last = '0;
    if (state == STATE_DATAWIDTH'(LOAD1_STATE))
      match_last = AW'(LOAD1_SIZE * LOAD1_SIZE - 1);
    else if (state == STATE_DATAWIDTH'(LOAD2_STATE))
      match_last = AW'(LOAD2_SIZE * LOAD2_SIZE - 1);
    else if (state == STATE_DATAWIDTH'(LOAD3_STATE))
      match_last = AW'(LOAD3_SIZE * LOAD3_SIZE - 1);
    else
      load_match = 1'b0;
  end

  assign stay      = (state == load_code);
  assign accept    = (fsm == LOAD) && bus.s_valid;
  assign lane_full = accept && (lane_cnt == LW'(COMPUTING_CORES - 1));
  assign final_smp = lane_full && (pix_cnt == last_pix);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt     = fsm;
    bus.s_ready = 1'b0;
    done        = 1'b0;
    case (fsm)
      IDLE: if (load_match) fsm_nxt = LOAD;
      LOAD: begin
        bus.s_ready = 1'b1;
        if (!stay)          fsm_nxt = IDLE;
        else if (final_smp) fsm_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!stay) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // The last lane is taken straight from the stream so the write issues the cycle after it.
  always_comb begin
    packed_lanes = '0;
    for (int unsigned k = 0; k < COMPUTING_CORES; k++)
      packed_lanes[k*DW +: DW] = (k == COMPUTING_CORES - 1) ? bus.s_data : lane_q[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_code <= '0;
      last_pix  <= '0;
      pix_cnt   <= '0;
      lane_cnt  <= '0;
      err_q     <= 1'b0;
      wr_ena_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int unsigned k = 0; k < COMPUTING_CORES; k++) lane_q[k] <= '0;
    end else begin
      wr_ena_q <= '0;
      if (fsm == IDLE && load_match) begin
        load_code <= state;
        last_pix  <= match_last;
        pix_cnt   <= '0;
        lane_cnt  <= '0;
        err_q     <= 1'b0;
      end
      // An abort cycle accepts nothing into the banks: partial lanes are simply dropped.
      if (accept && stay) begin
        if (bus.s_last != final_smp) err_q <= 1'b1;
        if (lane_full) begin
          lane_cnt  <= '0;
          pix_cnt   <= pix_cnt + 1'b1;
          wr_ena_q  <= '1;
          wr_addr_q <= {COMPUTING_CORES{pix_cnt}};
          wr_data_q <= packed_lanes;
        end else begin
          lane_q[lane_cnt] <= bus.s_data;
          lane_cnt         <= lane_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.wr_ena  = wr_ena_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign err_last    = err_q;
endmodule

// File: tb/tb_pool_fmap_loader.sv
// Directed-sequence bench for pool_fmap_loader with random data and valid gaps; writes are
// logged and compared against the expected per-address lane contents of each sample list.
module tb_pool_fmap_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic       done;
  logic       err_last;

  pool_fmap_loader_if #(
    .COMPUTING_CORES(4),
    .number_datawidth(16),
    .input_map_address_datawidth(13)
  ) bus ();

  pool_fmap_loader #(
    .COMPUTING_CORES(4),
    .number_datawidth(16),
    .input_map_address_datawidth(13),
    .STATE_DATAWIDTH(4),
    .LOAD1_STATE(2),
    .LOAD2_STATE(5),
    .LOAD3_STATE(8),
    .LOAD1_SIZE(80),
    .LOAD2_SIZE(36),
    .LOAD3_SIZE(14)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .bus(bus),
    .done(done),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ena;
    logic [51:0] addr;
    logic [63:0] data;
    logic        done;
    int unsigned cyc;
  } wr_t;

  wr_t         wr_log[$];
  wr_t         mon_w;
  logic [15:0] smp_data[$];
  bit          smp_last[$];
  int unsigned cyc = 0;
  bit          done_seen = 0;
  bit          exp_err = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_ena !== 4'h0) begin
      mon_w.ena  = bus.wr_ena;
      mon_w.addr = bus.wr_addr;
      mon_w.data = bus.wr_data;
      mon_w.done = done;
      mon_w.cyc  = cyc;
      wr_log.push_back(mon_w);
    end
    if (done === 1'b1) done_seen = 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, "_wr_ena"},  64'(bus.wr_ena),  64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, bus.wr_data,      64'd0);
    chk({tag, "_done"},    64'(done),        64'd0);
    chk({tag, "_err"},     64'(err_last),    64'd0);
  endtask

  task automatic prep(input int n, input bit idx, input bit final_last, input int extra_last);
    smp_data.delete();
    smp_last.delete();
    for (int i = 0; i < n; i++) begin
      smp_data.push_back(idx ? 16'(i) : 16'($urandom));
      smp_last.push_back((final_last && i == n - 1) || i == extra_last);
    end
  endtask

  // Offers samples until n_acc have been accepted; the model tracks the sticky err flag.
  task automatic drive(input int n_acc, input int pct, input int final_idx);
    int i = 0;
    int budget = 0;
    while (i < n_acc && budget < 40000) begin
      @(negedge clk);
      chk("err_track", 64'(err_last), 64'(exp_err));
      bus.s_valid = ($urandom_range(99) < pct);
      bus.s_data  = smp_data[i];
      bus.s_last  = smp_last[i];
      if (bus.s_valid && bus.s_ready) begin
        if (smp_last[i] != (i == final_idx)) exp_err = 1;
        i++;
      end
      budget++;
    end
    chk("drive_accepted", 64'(i), 64'(n_acc));
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n_wr, input bit complete, input bit steady);
    logic [63:0] e;
    logic [12:0] a13;
    chk({tag, "_count"}, 64'(wr_log.size()), 64'(n_wr));
    for (int a = 0; a < n_wr && a < wr_log.size(); a++) begin
      a13 = 13'(a);
      for (int k = 0; k < 4; k++) e[16*k +: 16] = smp_data[4*a + k];
      chk({tag, "_ena"},  64'(wr_log[a].ena),  64'hf);
      chk({tag, "_addr"}, 64'(wr_log[a].addr), 64'({4{a13}}));
      chk({tag, "_data"}, wr_log[a].data, e);
      chk({tag, "_done"}, 64'(wr_log[a].done), 64'(complete && a == n_wr - 1));
      if (steady && a > 0)
        chk({tag, "_rate"}, 64'(wr_log[a].cyc - wr_log[a-1].cyc), 64'd4);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    state = 4'd0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset held with random stream activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_valid = 1'($urandom);
      bus.s_data  = 16'($urandom);
      chk_all_zero("reset");
    end
    @(negedge clk);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_s_ready", 64'(bus.s_ready), 64'd0);
    end
    chk("post_reset_no_writes", 64'(wr_log.size()), 64'd0);

    // 14x14 map, continuous, value = index
    prep(784, 1, 1, -1);
    wr_log.delete();
    exp_err = 0;
    state = 4'd8;
    drive(784, 100, 783);
    idle_cycles(3);
    check_writes("l3", 196, 1, 1);
    chk("l3_done",    64'(done),        64'd1);
    chk("l3_err",     64'(err_last),    64'd0);
    chk("l3_s_ready", 64'(bus.s_ready), 64'd0);
    chk("l3_wr_ena",  64'(bus.wr_ena),  64'd0);

    // Move to an unrecognised code: done falls one cycle later
    state = 4'd9;
    #1 chk("chg_done_same", 64'(done), 64'd1);
    @(negedge clk);
    chk("chg_done_drop", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("code9_s_ready", 64'(bus.s_ready), 64'd0);
    end

    // 36x36 map, random data, 50% valid
    prep(5184, 0, 1, -1);
    wr_log.delete();
    exp_err = 0;
    state = 4'd5;
    drive(5184, 50, 5183);
    idle_cycles(3);
    check_writes("l2", 1296, 1, 0);
    chk("l2_done", 64'(done),     64'd1);
    chk("l2_err",  64'(err_last), 64'd0);
    state = 4'd0;
    idle_cycles(2);

    // 80x80 map aborted after 101 samples
    prep(101, 0, 0, -1);
    wr_log.delete();
    done_seen = 0;
    exp_err = 0;
    state = 4'd2;
    drive(101, 100, -1);
    state = 4'd0;
    @(negedge clk);
    chk("abort_s_ready", 64'(bus.s_ready), 64'd0);
    idle_cycles(5);
    check_writes("abort", 25, 0, 1);
    chk("abort_done_seen", 64'(done_seen), 64'd0);

    // 14x14 map with a stray s_last on sample 100
    prep(784, 0, 1, 100);
    wr_log.delete();
    exp_err = 0;
    state = 4'd8;
    drive(784, 100, 783);
    idle_cycles(3);
    check_writes("early_last", 196, 1, 1);
    chk("early_last_done", 64'(done),     64'd1);
    chk("early_last_err",  64'(err_last), 64'd1);
    state = 4'd0;
    idle_cycles(3);
    chk("err_sticky_idle", 64'(err_last), 64'd1);

    // Reload clears err_last and restarts at address 0
    prep(784, 0, 1, -1);
    wr_log.delete();
    exp_err = 0;
    state = 4'd8;
    drive(784, 100, 783);
    idle_cycles(3);
    check_writes("reload", 196, 1, 1);
    chk("reload_err", 64'(err_last), 64'd0);
    state = 4'd0;
    idle_cycles(2);

    // Missing s_last on the final sample
    prep(784, 0, 0, -1);
    wr_log.delete();
    exp_err = 0;
    state = 4'd8;
    drive(784, 100, 783);
    idle_cycles(3);
    check_writes("no_last", 196, 1, 1);
    chk("no_last_err", 64'(err_last), 64'd1);
    state = 4'd0;
    idle_cycles(2);

    // Asynchronous reset in the middle of a load
    prep(50, 0, 0, -1);
    wr_log.delete();
    exp_err = 0;
    state = 4'd2;
    drive(50, 100, -1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    state = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_async_s_ready", 64'(bus.s_ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
